uart_boot_loader: RTL and testbench

Controller that sequences the UART receiver into the CPU's 32-byte instruction memory. It holds the CPU, parses a framed program image from the received byte stream and writes each byte into instruction memory at consecutive addresses. It releases the CPU on success, or flags an error on a bad frame. It sits between the UART receiver's byte output and the instruction-memory write port, and drives the CPU hold/run control.

---
 rtl/uart_boot_loader.sv | 147 ++++++++++++++
 tb/tb_uart_boot_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// Boot loader: holds the CPU, copies a length-framed UART byte image into the 32-byte
// instruction memory, then releases the CPU. Define BOOT_CHECKSUM_EN to require a trailing checksum byte.
module uart_boot_loader #(
    parameter int TIMEOUT   = 208300,
    parameter int MEM_DEPTH = 32
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Load,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_fe,
    output logic       mem_we,
    output logic [4:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       done,
    output logic       err,
    output logic [5:0] byte_cnt
);
    localparam logic [7:0]  MAX_LEN = 8'(MEM_DEPTH);
    localparam logic [17:0] GAP_LIM = 18'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef BOOT_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERROR
    } state_e;

    state_e      state_q, state_d;
    logic [17:0] gap_q, gap_d;
    logic [5:0]  len_q, len_d, cnt_q, cnt_d;
    logic [4:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif
    logic        active, start, take, timeout;
    logic [5:0]  cnt_inc;

    assign active  = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign start   = Load && !active;
    assign take    = (state_q == S_DATA) && rx_valid && !rx_fe;
    // gap_q is the value before this edge; erroring at TIMEOUT-2 lands err exactly TIMEOUT-1 edges after the last byte
    assign timeout = active && !rx_valid && (gap_q == GAP_LIM);
    assign cnt_inc = cnt_q + 6'd1;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (Load) state_d = S_LEN;
            S_LEN: begin
                if (rx_valid) begin
                    if (rx_fe || rx_data == 8'd0 || rx_data > MAX_LEN) state_d = S_ERROR;
                    else                                               state_d = S_DATA;
                end else if (timeout) state_d = S_ERROR;
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (rx_fe) state_d = S_ERROR;
`ifdef BOOT_CHECKSUM_EN
                    else if (cnt_inc == len_q) state_d = S_CSUM;
`else
                    else if (cnt_inc == len_q) state_d = S_DONE;
`endif
                end else if (timeout) state_d = S_ERROR;
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_fe || rx_data != sum_q) state_d = S_ERROR;
                    else                           state_d = S_DONE;
                end else if (timeout) state_d = S_ERROR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gap_d   = gap_q;
        if (start)       gap_d = '0;
        else if (active) gap_d = rx_valid ? 18'd0 : gap_q + 18'd1;
        len_d   = (state_q == S_LEN && rx_valid && !rx_fe) ? rx_data[5:0] : len_q;
        cnt_d   = start ? 6'd0 : (take ? cnt_inc : cnt_q);
        we_d    = take;
        addr_d  = take ? cnt_q[4:0] : addr_q;
        wdata_d = take ? rx_data : wdata_q;
`ifdef BOOT_CHECKSUM_EN
        sum_d   = start ? 8'd0 : (take ? sum_q + rx_data : sum_q);
`endif
        // status flags follow the state being entered so they appear one cycle after their cause
        hold_d  = state_d inside {S_LEN, S_DATA, S_ERROR}
`ifdef BOOT_CHECKSUM_EN
                  || (state_d == S_CSUM)
`endif
                  ;
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERROR);
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign byte_cnt  = cnt_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader; follows BOOT_CHECKSUM_EN to send or omit the checksum byte.
module tb_uart_boot_loader;
    logic       Clk = 1'b0, Rst = 1'b1, Load = 1'b0, rx_valid = 1'b0, rx_fe = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       mem_we, cpu_hold, done, err;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [5:0] byte_cnt;

    int         total = 0, bad = 0, wr_total = 0;
    logic [4:0] wa [0:255];
    logic [7:0] wd [0:255];
    logic       both_hi = 1'b0;

`ifdef BOOT_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    always #5 Clk = ~Clk;

    uart_boot_loader #(.TIMEOUT(100)) dut (
        .Clk(Clk), .Rst(Rst), .Load(Load), .rx_valid(rx_valid), .rx_data(rx_data), .rx_fe(rx_fe),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .done(done), .err(err), .byte_cnt(byte_cnt)
    );

    // write log of the instruction-memory port
    always @(negedge Clk) begin
        if (mem_we) begin
            if (wr_total < 256) begin
                wa[wr_total] <= mem_addr;
                wd[wr_total] <= mem_wdata;
            end
            wr_total <= wr_total + 1;
        end
        if (done && err) both_hi <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_pulse();
        @(negedge Clk); Load = 1'b1;
        @(negedge Clk); Load = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe);
        @(negedge Clk); rx_valid = 1'b1; rx_data = b; rx_fe = fe;
    endtask

    task automatic rx_idle();
        @(negedge Clk); rx_valid = 1'b0; rx_fe = 1'b0;
        #1;
    endtask

    int base, cycles, errs;

    initial begin
        // reset values
        repeat (2) @(negedge Clk);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", byte_cnt, 0);
        Rst = 1'b0;

        // good frame 11,22,33 (+66)
        base = wr_total;
        load_pulse();
        chk("t1_hold_lat", cpu_hold, 1);
        send_byte(8'd3, 1'b0); rx_idle();
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
        if (CS) send_byte(8'h66, 1'b0);
        rx_idle();
        chk("t1_done", done, 1);
        chk("t1_hold", cpu_hold, 0);
        chk("t1_err", err, 0);
        chk("t1_cnt", byte_cnt, 3);
        chk("t1_nwr", wr_total - base, 3);
        chk("t1_a0", wa[base], 0);
        chk("t1_d0", wd[base], 8'h11);
        chk("t1_a2", wa[base+2], 2);
        chk("t1_d2", wd[base+2], 8'h33);

        // bad checksum (or, without checksum, a trailing byte after DONE is ignored)
        base = wr_total;
        if (CS) begin
            load_pulse();
            chk("t2_done_clr", done, 0);
            send_byte(8'd3, 1'b0);
            send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
            send_byte(8'h67, 1'b0);
            rx_idle();
            chk("t2_err", err, 1);
            chk("t2_hold", cpu_hold, 1);
            chk("t2_done", done, 0);
            chk("t2_nwr", wr_total - base, 3);
        end else begin
            send_byte(8'h44, 1'b0); rx_idle(); rx_idle();
            chk("t2_done", done, 1);
            chk("t2_cnt", byte_cnt, 3);
            chk("t2_nwr", wr_total - base, 0);
        end

        // illegal lengths 0 and 33
        base = wr_total;
        load_pulse();
        send_byte(8'h00, 1'b0); rx_idle();
        chk("t3_err0", err, 1);
        load_pulse();
        chk("t3_err_clr", err, 0);
        send_byte(8'h21, 1'b0); rx_idle();
        chk("t3_err33", err, 1);
        chk("t3_hold", cpu_hold, 1);
        chk("t3_nwr", wr_total - base, 0);

        // inter-byte timeout
        base = wr_total;
        load_pulse();
        send_byte(8'd4, 1'b0);
        send_byte(8'hA1, 1'b0); send_byte(8'hA2, 1'b0);
        rx_idle();
        cycles = 0;
        while (!err && cycles < 300) begin
            @(negedge Clk);
            cycles++;
        end
        chk("t4_tmo_cycles", cycles, 99);
        chk("t4_err", err, 1);
        chk("t4_cnt", byte_cnt, 2);
        chk("t4_nwr", wr_total - base, 2);

        // framing error on third data byte, then a good frame
        base = wr_total;
        load_pulse();
        send_byte(8'd4, 1'b0);
        send_byte(8'hC0, 1'b0); send_byte(8'hC1, 1'b0); send_byte(8'hC2, 1'b1);
        rx_idle();
        chk("t5_err", err, 1);
        chk("t5_nwr", wr_total - base, 2);
        chk("t5_a1", wa[base+1], 1);
        chk("t5_cnt", byte_cnt, 2);
        load_pulse();
        send_byte(8'd2, 1'b0); send_byte(8'hAA, 1'b0); send_byte(8'h55, 1'b0);
        if (CS) send_byte(8'hFF, 1'b0);
        rx_idle();
        chk("t5_done", done, 1);
        chk("t5_err_clr", err, 0);

        // full 32-byte image, back to back
        base = wr_total;
        load_pulse();
        send_byte(8'd32, 1'b0);
        for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b0);
        if (CS) send_byte(8'hF0, 1'b0);
        rx_idle();
        chk("t6_done", done, 1);
        chk("t6_cnt", byte_cnt, 32);
        chk("t6_nwr", wr_total - base, 32);
        errs = 0;
        for (int i = 0; i < 32; i++)
            if (wa[base+i] != 5'(i) || wd[base+i] != 8'(i)) errs++;
        chk("t6_wr_contents", errs, 0);
        chk("t6_last_addr", wa[base+31], 31);

        // reset in the middle of a repeat run
        load_pulse();
        send_byte(8'd32, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b0);
        @(negedge Clk); rx_valid = 1'b0; Rst = 1'b1;
        #1;
        chk("t7_rst_outs", {mem_we, mem_addr, mem_wdata, cpu_hold, done, err, byte_cnt}, 0);
        @(negedge Clk); Rst = 1'b0;
        base = wr_total;
        send_byte(8'h5A, 1'b0); rx_idle(); rx_idle();
        chk("t7_idle_ignore", wr_total - base, 0);
        chk("t7_hold", cpu_hold, 0);
        chk("done_err_excl", both_hi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
